// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   DEFAULT_WIDTH : default operand/result width
//   op_e          : 4-bit opcode encoding
//   state_e       : control FSM states
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_ADD = 4'b1110,
    OP_SUB = 4'b1101,
    OP_MUL = 4'b1100,
    OP_DIV = 4'b1011,
    OP_MOD = 4'b1010,
    OP_AND = 4'b1001,
    OP_OR  = 4'b1000,
    OP_XOR = 4'b0111,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle of the sequential ALU.
//   master (requester): drives start, op, A, B, Cin; reads S, flags, busy, done
//   slave  (ALU)      : the reverse
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Z;
  logic             N;
  logic             V;
  logic             DZ;
  logic             busy;
  logic             done;

  modport master (
    output start, op, A, B, Cin,
    input  S, Cout, Z, N, V, DZ, busy, done
  );

  modport slave (
    input  start, op, A, B, Cin,
    output S, Cout, Z, N, V, DZ, busy, done
  );

endinterface

// File: rtl/alu_divider.sv
// alu_divider: iterative restoring divider, one quotient bit per cycle.
//   clk, rst           : clock, synchronous active-high reset
//   start              : load dividend/divisor and begin (one-cycle pulse)
//   dividend, divisor  : unsigned operands, sampled only with start
//   quotient, remainder: result of the step being taken this cycle;
//                        meaningful only while valid is high
//   valid              : high in the cycle whose step is the last one
// The final step is presented combinationally so the caller can register
// the result on the same edge that completes the division. A zero divisor
// needs no special case: every trial subtraction succeeds, giving an
// all-ones quotient and a remainder equal to the dividend.
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;

  // The partial remainder stays below the divisor, so after a successful
  // subtraction the difference always fits in WIDTH bits.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    fits  = trial >= {1'b0, dvs_q};
    rem_n = fits ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
    quo_n = {quo_q[WIDTH-2:0], fits};
  end

  assign quotient  = quo_n;
  assign remainder = rem_n;
  assign valid     = run_q && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q + CW'(1);
      if (valid) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic/add/shift ops and
// WIDTH-cycle shift-add multiply and restoring divide/modulo.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_seq_if slave -- start/op/A/B/Cin in; registered S,
//              Cout/Z/N/V/DZ, busy (MUL/DIV in progress), done (one-cycle
//              pulse when results were just updated)
// Results and flags change only on the edge that enters DONE.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  op_e              op_q;
  logic             bzero_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] s_q;
  logic             cout_q, z_q, n_q, v_q, dz_q, busy_q, done_q;

  op_e              op_in;
  logic             is_mul_in;
  logic             is_div_in;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;

  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             div_valid;

  logic             finish;
  logic [WIDTH-1:0] next_s;
  logic             next_cout, next_v, next_dz;

  assign op_in     = op_e'(bus.op);
  assign is_mul_in = (op_in == OP_MUL);
  assign is_div_in = (op_in == OP_DIV) || (op_in == OP_MOD);

  assign add_full = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
  assign sub_full = {1'b0, bus.B} - {1'b0, bus.A};

  // One shift-add step on the {hi, lo} product register: lo starts as the
  // multiplier and is consumed LSB first while product bits shift in.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     ((state == ST_IDLE) && bus.start && is_div_in),
    .dividend  (bus.A),
    .divisor   (bus.B),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // finish marks the edge that enters DONE; next_* is what S and the flags
  // take on that edge. Unknown opcodes fall through with S=0.
  always_comb begin
    finish    = 1'b0;
    next_s    = '0;
    next_cout = 1'b0;
    next_v    = 1'b0;
    next_dz   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !is_mul_in && !is_div_in) begin
          finish = 1'b1;
          case (op_in)
            OP_ADD: begin
              next_s    = add_full[WIDTH-1:0];
              next_cout = add_full[WIDTH];
              next_v    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                          (add_full[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
              next_s    = sub_full[WIDTH-1:0];
              next_cout = sub_full[WIDTH];
              next_v    = (bus.B[WIDTH-1] != bus.A[WIDTH-1]) &&
                          (sub_full[WIDTH-1] != bus.B[WIDTH-1]);
            end
            OP_AND: next_s = bus.A & bus.B;
            OP_OR:  next_s = bus.A | bus.B;
            OP_XOR: next_s = bus.A ^ bus.B;
            OP_SHL: begin
              next_s    = {bus.A[WIDTH-2:0], 1'b0};
              next_cout = bus.A[WIDTH-1];
            end
            OP_SHR: begin
              next_s    = {1'b0, bus.A[WIDTH-1:1]};
              next_cout = bus.A[0];
            end
            default: next_s = '0;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == LAST) begin
          finish = 1'b1;
          next_s = mul_lo_n;
          next_v = |mul_hi_n;
        end
      end
      ST_DIV: begin
        if (div_valid) begin
          finish  = 1'b1;
          next_s  = (op_q == OP_DIV) ? div_quo : div_rem;
          next_dz = bzero_q;
        end
      end
      default: finish = 1'b0;
    endcase
  end

  // Control FSM with registered outputs. Multi-cycle ops latch their
  // operands here (multiplier) or in the divider, so later input changes
  // cannot disturb them; start outside IDLE is simply not looked at.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_ADD;
      bzero_q <= 1'b0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (finish) begin
        s_q    <= next_s;
        cout_q <= next_cout;
        v_q    <= next_v;
        dz_q   <= next_dz;
        z_q    <= (next_s == '0);
        n_q    <= next_s[WIDTH-1];
        busy_q <= 1'b0;
        done_q <= 1'b1;
        state  <= ST_DONE;
      end
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q    <= op_in;
            bzero_q <= (bus.B == '0);
            if (is_mul_in) begin
              mcand_q <= bus.A;
              hi_q    <= '0;
              lo_q    <= bus.B;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state   <= ST_MUL;
            end else if (is_div_in) begin
              busy_q <= 1'b1;
              state  <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          hi_q  <= mul_hi_n;
          lo_q  <= mul_lo_n;
          cnt_q <= cnt_q + CW'(1);
        end
        ST_DIV: begin
          busy_q <= ~finish;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.Z    = z_q;
  assign bus.N    = n_q;
  assign bus.V    = v_q;
  assign bus.DZ   = dz_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH SHALL default to 8 and set the operand and result width; legal values are 4 to 32.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; every register updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port start SHALL be an input, 1 bit wide: request to begin an operation, sampled only in IDLE.
REQ-006 Port op SHALL be an input, 4 bits wide: opcode.
REQ-007 Ports A and B SHALL be inputs, WIDTH bits wide each: unsigned operands.
REQ-008 Port Cin SHALL be an input, 1 bit wide: carry-in, used by ADD only.
REQ-009 Port S SHALL be an output, WIDTH bits wide: registered result.
REQ-010 Ports Cout, Z, N, V and DZ SHALL be outputs, 1 bit wide each: registered carry/borrow, zero, negative, overflow and divide-by-zero flags.
REQ-011 Port busy SHALL be an output, 1 bit wide: an operation is in progress.
REQ-012 Port done SHALL be an output, 1 bit wide: one-cycle pulse marking that S and the flags have just been updated.

Function
REQ-013 Opcodes SHALL be: 1110 ADD (A+B+Cin); 1101 SUB (B-A); 1100 MUL; 1011 DIV (A/B); 1010 MOD (A%B); 1001 AND; 1000 OR; 0111 XOR; 0110 SHL (A<<1); 0101 SHR (A>>1).
REQ-014 Any other opcode SHALL produce S=0, Z=1 and all other flags 0, with single-cycle timing.
REQ-015 The FSM SHALL have states IDLE, MUL, DIV and DONE; start is accepted only in IDLE.
REQ-016 On acceptance, A, B, op and Cin SHALL be latched, and later input changes SHALL have no effect on the operation in progress.
REQ-017 Single-cycle ops SHALL go IDLE->DONE, so done is high in the cycle after the accepting edge.
REQ-018 MUL SHALL be an iterative shift-add over WIDTH cycles in state MUL, followed by DONE, with done high exactly WIDTH+1 cycles after the accepting edge.
REQ-019 DIV and MOD SHALL be a restoring division over WIDTH cycles in state DIV, followed by DONE, with the same WIDTH+1 latency.
REQ-020 busy SHALL be high in MUL and DIV and low in IDLE and DONE; busy and done are never high together.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE; start during DONE or while busy SHALL be ignored and not queued.
REQ-022 S and all flags SHALL update only at the edge entering DONE and SHALL otherwise hold.
REQ-023 Z SHALL equal (S==0) and N SHALL equal S[WIDTH-1], for every op.
REQ-024 Cout SHALL be: ADD carry-out; SUB borrow (1 when A>B); SHL the bit shifted out of A[WIDTH-1]; SHR the bit shifted out of A[0]; 0 for all other ops.
REQ-025 V SHALL be: ADD/SUB two's-complement overflow; MUL 1 when the upper WIDTH bits of the 2*WIDTH product are nonzero (S holds the low half); 0 for all other ops.
REQ-026 DIV with B=0 SHALL give S all ones and DZ=1; MOD with B=0 SHALL give S=A and DZ=1; the latency SHALL be unchanged; DZ is 0 for every other case.

Reset
REQ-027 When rst is high at an edge, state SHALL become IDLE and S, Cout, Z, N, V, DZ, busy and done SHALL all become 0.
REQ-028 rst SHALL take priority over start.
REQ-029 Reset mid-operation SHALL abort the operation, produce no done pulse and discard the partial result.
REQ-030 The first start SHALL be accepted in the cycle after rst deasserts.

Structure
REQ-031 Package alu_pkg SHALL hold the opcode enum, the FSM state enum and the default WIDTH constant.
REQ-032 The iterative divider SHALL be sub-module alu_divider (inputs: start, dividend, divisor; outputs: quotient, remainder, valid), instantiated once.
REQ-033 The multiplier SHALL be inline in alu_seq.

Verification (WIDTH=8)
REQ-034 ADD A=200, B=100, Cin=0 -> S=44, Cout=1, Z=0, done one cycle after accept.
REQ-035 SUB A=3, B=1 -> S=0xFE, Cout=1, N=1; then SUB A=3, B=10 -> S=7, Cout=0, N=0.
REQ-036 MUL A=16, B=16 -> S=0, V=1, Z=1, done exactly 9 cycles after accept with busy high for 8 cycles; then MUL 3x5 -> S=15, V=0.
REQ-037 DIV 200/7 -> S=28; MOD 200%7 -> S=4; DIV 9/0 -> S=0xFF, DZ=1; MOD 9%0 -> S=9, DZ=1.
REQ-038 SHL A=0xA5 -> S=0x4A, Cout=1; SHR A=0x05 -> S=0x02, Cout=1.
REQ-039 A second start during MUL busy is ignored and the result matches the first request; rst asserted at iteration 4 of DIV gives busy=0, done never pulses, and all outputs are 0.
